// File: rtl/matmul_apb_arbiter.sv
// Two-master APB arbiter in front of the matmul accelerator slave port.
// Round-robin grants, one full APB transfer per grant, and a start-command
// lock that reserves the accelerator for the starting master until its run
// completes (busy_i falls) or busy_i never rises within LOCK_TIMEOUT cycles.
module matmul_apb_arbiter #(
    parameter int BUS_WIDTH    = 32,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_DIM      = BUS_WIDTH / DATA_WIDTH,
    parameter int ADDR_WIDTH   = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              m_psel_i,
    input  logic [1:0]              m_penable_i,
    input  logic [1:0]              m_pwrite_i,
    input  logic [2*ADDR_WIDTH-1:0] m_paddr_i,
    input  logic [2*BUS_WIDTH-1:0]  m_pwdata_i,
    input  logic [2*MAX_DIM-1:0]    m_pstrb_i,
    output logic [BUS_WIDTH-1:0]    m_prdata_o,
    output logic [1:0]              m_pready_o,
    output logic [1:0]              m_pslverr_o,
    output logic                    s_psel_o,
    output logic                    s_penable_o,
    output logic                    s_pwrite_o,
    output logic [ADDR_WIDTH-1:0]   s_paddr_o,
    output logic [BUS_WIDTH-1:0]    s_pwdata_o,
    output logic [MAX_DIM-1:0]      s_pstrb_o,
    input  logic [BUS_WIDTH-1:0]    s_prdata_i,
    input  logic                    s_pready_i,
    input  logic                    s_pslverr_i,
    input  logic                    busy_i,
    output logic                    lock_o,
    output logic                    owner_o
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    gnt_q;
    logic                    last_grant_q;
    logic [1:0]              blocked;
    logic [1:0]              eligible;
    logic                    grant_sel;
    logic                    grant_en;
    logic                    xfer_done;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [BUS_WIDTH-1:0]    sel_wdata;
    logic [MAX_DIM-1:0]      sel_strb;
    logic                    start_hit;
    logic                    release_hit;
    logic                    seen_busy_q;
    logic [CNT_W-1:0]        cnt_q;

    // Master penable carries no information here: a granted master is
    // served from its psel-time fields and stalls until its pready.
    logic unused_penable;
    assign unused_penable = ^m_penable_i;

    // Eligibility, round-robin pick and the selected master's request fields.
    always_comb begin
        blocked = '0;
        if (lock_o) begin
            blocked[~owner_o] = 1'b1;
        end
        eligible  = m_psel_i & ~blocked;
        grant_sel = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
        sel_write = grant_sel ? m_pwrite_i[1] : m_pwrite_i[0];
        sel_addr  = grant_sel ? m_paddr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_paddr_i[ADDR_WIDTH-1:0];
        sel_wdata = grant_sel ? m_pwdata_i[2*BUS_WIDTH-1:BUS_WIDTH] : m_pwdata_i[BUS_WIDTH-1:0];
        sel_strb  = grant_sel ? m_pstrb_i[2*MAX_DIM-1:MAX_DIM] : m_pstrb_i[MAX_DIM-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-state strobes.
    always_comb begin
        state_d   = state_q;
        grant_en  = 1'b0;
        xfer_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    grant_en = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (s_pready_i) begin
                    xfer_done = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A start is a successful write of CONTROL with bit 0 of byte 0 set.
    assign start_hit = xfer_done && s_pwrite_o && (s_paddr_o[4:0] == 5'b00000)
                       && s_pstrb_o[0] && s_pwdata_o[0] && !s_pslverr_i;

    assign release_hit = lock_o && (seen_busy_q ? !busy_i : (cnt_q == CNT_MAX));

    // Registered slave-side bus, grant bookkeeping and master responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            s_psel_o     <= 1'b0;
            s_penable_o  <= 1'b0;
            s_pwrite_o   <= 1'b0;
            s_paddr_o    <= '0;
            s_pwdata_o   <= '0;
            s_pstrb_o    <= '0;
            m_prdata_o   <= '0;
            m_pready_o   <= '0;
            m_pslverr_o  <= '0;
        end else begin
            m_pready_o  <= '0;
            m_pslverr_o <= '0;
            if (grant_en) begin
                gnt_q        <= grant_sel;
                last_grant_q <= grant_sel;
                s_psel_o     <= 1'b1;
                s_pwrite_o   <= sel_write;
                s_paddr_o    <= sel_addr;
                s_pwdata_o   <= sel_wdata;
                s_pstrb_o    <= sel_strb;
            end
            if (state_q == SETUP) begin
                s_penable_o <= 1'b1;
            end
            if (xfer_done) begin
                s_psel_o            <= 1'b0;
                s_penable_o         <= 1'b0;
                m_prdata_o          <= s_prdata_i;
                m_pready_o[gnt_q]   <= 1'b1;
                m_pslverr_o[gnt_q]  <= s_pslverr_i;
            end
        end
    end

    // Accelerator lock; a fresh start takes precedence over a release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_o      <= 1'b0;
            owner_o     <= 1'b0;
            seen_busy_q <= 1'b0;
            cnt_q       <= '0;
        end else if (start_hit) begin
            lock_o      <= 1'b1;
            owner_o     <= gnt_q;
            seen_busy_q <= 1'b0;
            cnt_q       <= '0;
        end else if (release_hit) begin
            lock_o      <= 1'b0;
            seen_busy_q <= 1'b0;
            cnt_q       <= '0;
        end else if (lock_o) begin
            if (busy_i) begin
                seen_busy_q <= 1'b1;
            end
            if (!seen_busy_q && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
